// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - ASCII constants, FSM encoding and expected-echo record for serial_echo_checker
package serial_pkg;

  localparam logic [7:0] BS          = 8'h08;
  localparam logic [7:0] DEL         = 8'h7F;
  localparam logic [7:0] CR          = 8'h0D;
  localparam logic [7:0] LF          = 8'h0A;
  localparam logic [7:0] SP          = 8'h20;
  localparam logic [7:0] CASE_OFFSET = 8'h20;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SEND   = 3'd1;
  localparam logic [2:0] ST_ACCEPT = 3'd2;
  localparam logic [2:0] ST_EXPECT = 3'd3;
  localparam logic [2:0] ST_DRAIN  = 3'd4;
  localparam logic [2:0] ST_RESULT = 3'd5;

  typedef struct packed {
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
    logic [1:0] len;
  } exp_seq_t;

endpackage

// File: rtl/echo_expect.sv
// rtl/echo_expect.sv - echo the responder must return for one sent byte
module echo_expect
  import serial_pkg::*;
(
  input  logic [7:0] b,
  output logic [7:0] exp0,
  output logic [7:0] exp1,
  output logic [7:0] exp2,
  output logic [1:0] exp_len
);

  always_comb begin
    exp0    = b;
    exp1    = 8'h00;
    exp2    = 8'h00;
    exp_len = 2'd1;
    if (b == BS || b == DEL) begin
      exp0    = BS;
      exp1    = SP;
      exp2    = BS;
      exp_len = 2'd3;
    end else if (b == CR) begin
      exp1    = LF;
      exp_len = 2'd2;
    end else if (b >= 8'h61 && b <= 8'h7A) begin
      exp0 = b - CASE_OFFSET;
    end else if (b >= 8'h41 && b <= 8'h5A) begin
      exp0 = b + CASE_OFFSET;
    end
  end

endmodule

// File: rtl/serial_echo_checker.sv
// rtl/serial_echo_checker.sv - sends a byte sequence to the echo responder and checks each echo
module serial_echo_checker
  import serial_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 250_000,
  parameter int         DRAIN_CYCLES   = 50_000,
  parameter logic [7:0] START_BYTE     = 8'h00,
  parameter int         CNT_W          = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  output logic [7:0]       o_tx_data,
  output logic             o_tx_start,
  input  logic             i_tx_busy,
  input  logic [7:0]       i_rx_data,
  input  logic             i_rx_valid,
  output logic             o_busy,
  output logic [7:0]       o_last_sent,
  output logic [CNT_W-1:0] o_pass_count,
  output logic [CNT_W-1:0] o_err_count,
  output logic             o_err
);

  localparam int WAIT_MAX = (TIMEOUT_CYCLES > DRAIN_CYCLES) ? TIMEOUT_CYCLES : DRAIN_CYCLES;
  localparam int TW       = $clog2(WAIT_MAX + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] DRAIN_LAST   = TW'(DRAIN_CYCLES - 1);

  logic [2:0]    state;
  logic [7:0]    pattern;
  exp_seq_t      exp_seq;
  logic [1:0]    exp_idx;
  logic [TW-1:0] timer;
  logic          failed;

  logic [7:0] next_b0, next_b1, next_b2, exp_cur;
  logic [1:0] next_len;
  logic       rx_hit, rx_match, rx_done, rx_miss;

  echo_expect u_expect (
    .b       (pattern),
    .exp0    (next_b0),
    .exp1    (next_b1),
    .exp2    (next_b2),
    .exp_len (next_len)
  );

  always_comb begin
    case (exp_idx)
      2'd0:    exp_cur = exp_seq.b0;
      2'd1:    exp_cur = exp_seq.b1;
      default: exp_cur = exp_seq.b2;
    endcase
  end

  // The echo may start before uart_tx drops busy, so SEND and ACCEPT compare too.
  assign rx_hit   = i_rx_valid && (state == ST_SEND || state == ST_ACCEPT || state == ST_EXPECT);
  assign rx_match = (i_rx_data == exp_cur);
  assign rx_done  = rx_hit && rx_match && ((exp_idx + 2'd1) == exp_seq.len);
  assign rx_miss  = rx_hit && !rx_match;
  assign o_busy   = (state != ST_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      pattern      <= START_BYTE;
      exp_seq      <= '0;
      exp_idx      <= 2'd0;
      timer        <= '0;
      failed       <= 1'b0;
      o_tx_data    <= 8'h00;
      o_tx_start   <= 1'b0;
      o_last_sent  <= 8'h00;
      o_pass_count <= '0;
      o_err_count  <= '0;
      o_err        <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_rx_valid) begin
            if (o_err_count != {CNT_W{1'b1}}) o_err_count <= o_err_count + 1'b1;
            o_err <= 1'b1;
          end
          if (i_enable) begin
            o_last_sent <= pattern;
            exp_seq     <= {next_b0, next_b1, next_b2, next_len};
            failed      <= 1'b0;
            state       <= ST_SEND;
          end
        end
        ST_SEND, ST_ACCEPT, ST_EXPECT: begin
          if (rx_hit && rx_match) exp_idx <= exp_idx + 2'd1;
          if (state == ST_EXPECT) timer <= i_rx_valid ? '0 : timer + 1'b1;
          if (rx_done) begin
            state <= ST_RESULT;
          end else if (rx_miss) begin
            failed <= 1'b1;
            timer  <= '0;
            state  <= ST_DRAIN;
          end else if (state == ST_SEND) begin
            if (!i_tx_busy) begin
              o_tx_data  <= o_last_sent;
              o_tx_start <= 1'b1;
              state      <= ST_ACCEPT;
            end
          end else if (state == ST_ACCEPT) begin
            if (i_tx_busy) begin
              timer <= '0;
              state <= ST_EXPECT;
            end
          end else if (!i_rx_valid && timer == TIMEOUT_LAST) begin
            failed <= 1'b1;
            state  <= ST_RESULT;
          end
        end
        ST_DRAIN: begin
          if (i_rx_valid) begin
            timer <= '0;
          end else if (timer == DRAIN_LAST) begin
            state <= ST_RESULT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESULT: begin
          if (failed) begin
            if (o_err_count != {CNT_W{1'b1}}) o_err_count <= o_err_count + 1'b1;
            o_err <= 1'b1;
          end else if (o_pass_count != {CNT_W{1'b1}}) begin
            o_pass_count <= o_pass_count + 1'b1;
          end
          pattern <= pattern + 8'd1;
          exp_idx <= 2'd0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/serial_echo_checker.md
Name: serial_echo_checker

Overview:
- Host-side initiator for the swapped-case serial echo responder; drives a uart_tx byte interface and consumes a uart_rx byte interface.
- Transmits a deterministic byte sequence, computes the exact echo the responder must return (case swap, CR→CR LF, BS/DEL→BS SP BS) and compares it byte by byte.
- Counts passing and failing transactions. Used as a loopback self-test, on-board or in simulation against the echo top.

Parameters:
- TIMEOUT_CYCLES, 250_000, max clocks to wait for each expected echo byte (10 ms at 25 MHz).
- DRAIN_CYCLES, 50_000, rx-silent clocks required after a mismatch before the next transaction.
- START_BYTE, 8'h00, first byte sent after reset.
- CNT_W, 16, width of the pass and error counters.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_enable  in  1  level; run transactions continuously while high
- o_tx_data  out  8  byte to uart_tx
- o_tx_start  out  1  one-cycle start pulse to uart_tx
- i_tx_busy  in  1  uart_tx busy
- i_rx_data  in  8  byte from uart_rx
- i_rx_valid  in  1  one-cycle strobe from uart_rx
- o_busy  out  1  high whenever the FSM is not in IDLE
- o_last_sent  out  8  byte of the current or most recent transaction
- o_pass_count  out  CNT_W  saturating count of passing transactions
- o_err_count  out  CNT_W  saturating count of failures
- o_err  out  1  sticky; set on the first failure, cleared only by reset

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, all outputs 0, pattern register=START_BYTE, exp_idx=0.
- Expected sequence for sent byte b, with length exp_len:
  - b==08 or b==7F: {08,20,08}, length 3
  - b==0D: {0D,0A}, length 2
  - b in 61..7A: {b-20}, length 1
  - b in 41..5A: {b+20}, length 1
  - otherwise: {b}, length 1
- IDLE: when i_enable=1, latch o_last_sent=pattern, build the expected sequence, go to SEND.
- SEND: when i_tx_busy=0, drive o_tx_data=o_last_sent and pulse o_tx_start for exactly 1 cycle, then go to ACCEPT.
- ACCEPT: wait for i_tx_busy=1, then go to EXPECT and clear the timeout counter. There is no timeout in ACCEPT.
- EXPECT: the timeout counter increments each cycle and resets on every i_rx_valid.
  - i_rx_valid with i_rx_data==exp[exp_idx]: exp_idx++; when exp_idx reaches exp_len, go to RESULT with pass.
  - i_rx_valid with a mismatch: mark fail, go to DRAIN.
  - Counter reaches TIMEOUT_CYCLES: mark fail, go to RESULT.
- An i_rx_valid arriving while the FSM is in SEND or ACCEPT is compared exactly as in EXPECT. The echo may begin before uart_tx deasserts busy.
- DRAIN: the counter resets on any i_rx_valid; go to RESULT after DRAIN_CYCLES consecutive silent cycles.
- RESULT (1 cycle):
  - Pass: o_pass_count++.
  - Fail: o_err_count++ and o_err=1.
  - Both counters saturate at all-ones.
  - Pattern += 1 (FF wraps to 00); exp_idx=0.
  - Go to IDLE. Back-to-back transactions therefore pass through IDLE, with one cycle of gap.
- i_rx_valid while in IDLE: stray byte; o_err_count++ and o_err=1. If it coincides with i_enable, the stray is counted and the transaction still starts.
- i_enable deasserted mid-transaction: the current transaction completes and is counted; then the FSM stays in IDLE.
- Reset mid-transaction: immediate return to reset values. Any in-flight uart_tx frame finishes on its own.
- Each transaction counts at most one failure.

Decomposition:
- Package serial_pkg holds the ASCII constants (BS=08, DEL=7F, CR=0D, LF=0A, SP=20, CASE_OFFSET=20) and the FSM state encoding.
- Sub-module echo_expect: combinational. Input: 8-bit b. Outputs: exp0, exp1, exp2 and a 2-bit exp_len. Reused by the testbench scoreboard.

Test Plan:
- Reset, START_BYTE=61, i_enable=1, model returns 41 → one o_tx_start with o_tx_data=61; o_pass_count=1; o_last_sent moves to 62.
- Send 0D, model returns 0D then 0A → pass. Returning only 0D → timeout after TIMEOUT_CYCLES (set to 1000 in the bench); o_err_count=1, o_err=1.
- Send 7F, model returns 08,20,08 → pass. Returning 08,08,20 → mismatch on the second byte; DRAIN absorbs the trailing 20; err=1; next sent byte is 80.
- Run 256 transactions against the real echo top through a loopback → o_pass_count=256, o_err_count=0; pattern wraps from FF to 00.
- Inject i_rx_valid=1 with 55 while in IDLE with i_enable=0 → o_err_count=1, o_err=1; no o_tx_start.
- Assert i_rst_n=0 during EXPECT → outputs 0 on the same edge; after release with i_enable=1, the first sent byte is START_BYTE.
